// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the PC fetch sequencer
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_REDIR,
        SEL_PEND
    } sel_t;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_buffer.sv
// rtl/pc_redirect_buffer.sv - jump/branch priority mux and one-entry pending redirect
module pc_redirect_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        fire,
    input  logic        capture_en,
    output logic        redir,
    output logic [31:0] tgt,
    output logic        pending_v,
    output logic [31:0] pending
);

    assign redir = jump | branch_taken;
    assign tgt   = jump ? jump_target : branch_target;

    // A redirect that cannot be consumed now is parked; a newer one replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_v <= 1'b0;
            pending   <= 32'h0000_0000;
        end else if (fire) begin
            pending_v <= 1'b0;
        end else if (redir && capture_en) begin
            pending_v <= 1'b1;
            pending   <= tgt;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC register, next-PC arbitration and fetch handshake FSM
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        FetchReady,
    output logic [31:0] PCResult,
    output logic        FetchValid,
    output logic [31:0] FetchCount,
    output logic        Halted,
    output logic        AlignFault
);

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_t      state;
    state_t      state_next;
    sel_t        sel;
    logic        fire;
    logic        redir;
    logic [31:0] tgt;
    logic        pending_v;
    logic [31:0] pending;
    logic [31:0] sel_target;
    logic        misaligned;
    logic [31:0] next_pc;
    logic        fault_next;
    logic        capture_en;

    assign fire       = FetchValid & FetchReady & ~Stall;
    assign capture_en = (state != HALT);

    pc_redirect_buffer u_redirect_buffer (
        .clk           (Clk),
        .rst           (Reset),
        .jump          (Jump),
        .jump_target   (JumpTarget),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .fire          (fire),
        .capture_en    (capture_en),
        .redir         (redir),
        .tgt           (tgt),
        .pending_v     (pending_v),
        .pending       (pending)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = Halt ? HALT : FETCH;
            FETCH:   state_next = Halt ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Live redirect beats a parked one, which beats the sequential PC.
    always_comb begin
        sel = SEL_SEQ;
        if (redir) begin
            sel = SEL_REDIR;
        end else if (pending_v) begin
            sel = SEL_PEND;
        end
    end

    always_comb begin
        sel_target = (sel == SEL_REDIR) ? tgt : pending;
        misaligned = (sel_target[1:0] != 2'b00);
        next_pc    = PCAddResult;
        fault_next = 1'b0;
        if (sel != SEL_SEQ) begin
            if (ALIGN_CHECK && misaligned) begin
                next_pc    = EXC_VECTOR;
                fault_next = 1'b1;
            end else begin
                next_pc = {sel_target[31:2], 2'b00};
            end
        end
    end

    // Valid and halted are registered from the next state so they line up with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PCResult   <= RESET_PC;
            FetchValid <= 1'b0;
            FetchCount <= 32'h0000_0000;
            Halted     <= 1'b0;
            AlignFault <= 1'b0;
        end else begin
            if (fire) begin
                PCResult   <= next_pc;
                FetchCount <= FetchCount + 32'd1;
            end
            FetchValid <= (state_next == FETCH);
            Halted     <= (state_next == HALT);
            AlignFault <= fire & fault_next;
        end
    end

endmodule
